// File: rtl/exp_fmt_pkg.sv
// Fixed-point format definitions shared by the exp evaluator output stages.
// Q7.25 evaluator results are narrowed to unsigned Q4.12 for the consumer.
package exp_fmt_pkg;

    localparam int Q_IN_FRAC  = 25;
    localparam int Q_OUT_FRAC = 12;
    localparam int Q_OUT_INT  = 4;
    localparam int SHIFT      = Q_IN_FRAC - Q_OUT_FRAC;

    typedef logic [31:0] q725_t;
    typedef logic [15:0] q412_t;

    localparam q412_t SAT_MAX = 16'hFFFF;

endpackage

// File: rtl/q725_to_q412_sat.sv
// Unsigned Q7.25 -> Q4.12 conversion with round-half-up and saturation.
// Purely combinational so it can sit directly on any push path.
module q725_to_q412_sat
    import exp_fmt_pkg::*;
(
    input  q725_t y,
    output q412_t z,
    output logic  sat
);

    logic [18:0] trunc;
    logic [19:0] rounded;

    // The bit just below the kept LSB decides round-up; the carry can reach bit 19.
    assign trunc   = y[31:SHIFT];
    assign rounded = {1'b0, trunc} + {19'd0, y[SHIFT-1]};
    assign sat     = |rounded[19:16];
    assign z       = sat ? SAT_MAX : rounded[15:0];

endmodule

// File: rtl/exp_result_fifo.sv
// Output stage of the exp evaluator: converts Q7.25 results to Q4.12 and
// buffers them in a register FIFO, with saturation and overflow debug counters.
module exp_result_fifo
    import exp_fmt_pkg::*;
#(
    parameter int WIDTHIN  = 32,
    parameter int WIDTHOUT = 16,
    parameter int DEPTH    = 8,
    parameter int CNTW     = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [WIDTHIN-1:0]  i_y,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [WIDTHOUT-1:0] o_z,
    input  logic                i_flush,
    output logic [CNTW-1:0]     o_count,
    output logic [7:0]          o_sat_cnt,
    output logic                o_ovf
);

    localparam int PTRW = $clog2(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and o_ready depends only on count.

    q412_t            mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [CNTW-1:0]  count;
    q412_t            conv_z;
    logic             conv_sat;
    logic             push;
    logic             pop;
    logic             full;

    q725_to_q412_sat u_conv (
        .y   (i_y),
        .z   (conv_z),
        .sat (conv_sat)
    );

    assign full    = (count == CNTW'(DEPTH));
    assign o_ready = !full;
    assign o_valid = (count != '0);
    assign o_count = count;
    assign o_z     = mem[rd_ptr];

    // Flush wins over any transfer in the same cycle.
    assign push = i_valid && o_ready && !i_flush;
    assign pop  = o_valid && i_ready && !i_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_sat_cnt <= '0;
            o_ovf     <= 1'b0;
        end else begin
            if (i_valid && full) begin
                o_ovf <= 1'b1;
            end
            if (push && conv_sat && (o_sat_cnt != 8'hFF)) begin
                o_sat_cnt <= o_sat_cnt + 8'd1;
            end
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTRW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTRW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNTW'(1);
                    2'b01:   count <= count - CNTW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage carries no reset; entries are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= conv_z;
        end
    end

endmodule
